// File: rtl/cache_arbiter_if.sv
// Signal bundle between the two L1 caches, the arbiter and the cacheline adaptor.
// The slave modport is the arbiter's view; master is the requester/adaptor side.
interface cache_arbiter_if;
  logic [31:0]  i_address_i;
  logic         i_read_i;
  logic [255:0] i_line_o;
  logic         i_resp_o;

  logic [31:0]  d_address_i;
  logic         d_read_i;
  logic         d_write_i;
  logic [255:0] d_line_i;
  logic [255:0] d_line_o;
  logic         d_resp_o;

  logic [31:0]  address_o;
  logic [255:0] line_o;
  logic         read_o;
  logic         write_o;
  logic [255:0] line_i;
  logic         resp_i;

  modport slave (
    input  i_address_i, i_read_i,
    input  d_address_i, d_read_i, d_write_i, d_line_i,
    input  line_i, resp_i,
    output i_line_o, i_resp_o, d_line_o, d_resp_o,
    output address_o, line_o, read_o, write_o
  );

  modport master (
    output i_address_i, i_read_i,
    output d_address_i, d_read_i, d_write_i, d_line_i,
    output line_i, resp_i,
    input  i_line_o, i_resp_o, d_line_o, d_resp_o,
    input  address_o, line_o, read_o, write_o
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin 2:1 arbiter sharing one line-granular adaptor port between the
// I-cache and D-cache; one transaction in flight, all outputs registered.
module cache_arbiter (
  input  logic           clk,
  input  logic           reset_n,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state;
  logic   owner_d;
  logic   op_wr;
  logic   last_grant_d;

  logic   i_req;
  logic   d_req;
  logic   grant_d;
  logic   grant_wr;

  // On a tie the side that did not win last time is granted.
  always_comb begin
    i_req    = bus.i_read_i;
    d_req    = bus.d_read_i | bus.d_write_i;
    grant_d  = d_req & (~i_req | ~last_grant_d);
    grant_wr = grant_d & bus.d_write_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      op_wr         <= 1'b0;
      last_grant_d  <= 1'b0;
      bus.address_o <= '0;
      bus.line_o    <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.i_line_o  <= '0;
      bus.d_line_o  <= '0;
      bus.i_resp_o  <= 1'b0;
      bus.d_resp_o  <= 1'b0;
    end else begin
      bus.read_o   <= 1'b0;
      bus.write_o  <= 1'b0;
      bus.i_resp_o <= 1'b0;
      bus.d_resp_o <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            owner_d       <= grant_d;
            last_grant_d  <= grant_d;
            op_wr         <= grant_wr;
            bus.address_o <= grant_d ? bus.d_address_i : bus.i_address_i;
            if (grant_wr) bus.line_o <= bus.d_line_i;
            // Start pulse is registered here so it is high exactly during ISSUE.
            bus.read_o    <= ~grant_wr;
            bus.write_o   <= grant_wr;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.resp_i) begin
            if (!op_wr) begin
              if (owner_d) bus.d_line_o <= bus.line_i;
              else         bus.i_line_o <= bus.line_i;
            end
            if (owner_d) bus.d_resp_o <= 1'b1;
            else         bus.i_resp_o <= 1'b1;
            state <= DONE;
          end
        end
        // Requests are still high here; going straight to IDLE avoids re-granting them.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized
// traffic compared against a request-level reference model.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if ifc();
  cache_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(ifc.slave));

  int checks = 0;
  int errors = 0;

  int   n_rd = 0, n_wr = 0, n_iresp = 0, n_dresp = 0, n_both = 0, n_consec = 0;
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    n_rd       <= n_rd + int'(ifc.read_o);
    n_wr       <= n_wr + int'(ifc.write_o);
    n_iresp    <= n_iresp + int'(ifc.i_resp_o);
    n_dresp    <= n_dresp + int'(ifc.d_resp_o);
    n_both     <= n_both + int'(ifc.read_o & ifc.write_o);
    n_consec   <= n_consec + int'((ifc.read_o | ifc.write_o) & prev_pulse);
    prev_pulse <= ifc.read_o | ifc.write_o;
  end

  // reference model state
  bit           m_last_d;
  logic [255:0] m_i_line, m_d_line;

  // observations from the adaptor responder
  logic         obs_rd, obs_wr;
  logic [31:0]  obs_addr;
  logic [255:0] obs_wline;
  bit           obs_to;
  int           obs_unstable;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    ifc.i_address_i = '0; ifc.i_read_i = 1'b0;
    ifc.d_address_i = '0; ifc.d_read_i = 1'b0; ifc.d_write_i = 1'b0; ifc.d_line_i = '0;
    ifc.line_i = '0; ifc.resp_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    m_last_d = 1'b0; m_i_line = '0; m_d_line = '0;
  endtask

  // Adaptor responder: waits for a start pulse, answers after lat cycles,
  // and returns at the negedge of the cycle in which the owner's resp is due.
  task automatic serve(input int lat, input logic [255:0] rl);
    int n;
    obs_to = 1'b0; obs_unstable = 0; obs_rd = 1'b0; obs_wr = 1'b0;
    obs_addr = '0; obs_wline = '0;
    n = 0;
    while (!(ifc.read_o || ifc.write_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(ifc.read_o || ifc.write_o)) begin
      obs_to = 1'b1;
      return;
    end
    obs_rd = ifc.read_o; obs_wr = ifc.write_o;
    obs_addr = ifc.address_o; obs_wline = ifc.line_o;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (ifc.address_o !== obs_addr || ifc.line_o !== obs_wline) obs_unstable++;
    end
    ifc.resp_i = 1'b1; ifc.line_i = rl;
    @(negedge clk);
    ifc.resp_i = 1'b0; ifc.line_i = rand256();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.read_o, ifc.write_o, ifc.i_resp_o, ifc.d_resp_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {ifc.read_o, ifc.write_o, ifc.i_resp_o, ifc.d_resp_o});
    end
    checks++;
    if (ifc.address_o !== 32'h0 || ifc.line_o !== 256'h0) begin
      errors++;
      $display("FAIL reset_bus got addr %h line %h want 0", ifc.address_o, ifc.line_o);
    end
    checks++;
    if (ifc.i_line_o !== 256'h0 || ifc.d_line_o !== 256'h0) begin
      errors++;
      $display("FAIL reset_lines got i %h d %h want 0", ifc.i_line_o, ifc.d_line_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
    m_last_d = 1'b0; m_i_line = '0; m_d_line = '0;
  endtask

  task automatic test_i_read();
    logic [255:0] a5;
    int rd0, ir0, dr0;
    a5 = {32{8'hA5}};
    rd0 = n_rd; ir0 = n_iresp; dr0 = n_dresp;
    ifc.i_address_i = 32'h0000_1040; ifc.i_read_i = 1'b1;
    serve(6, a5);
    checks++;
    if (obs_to !== 1'b0) begin errors++; $display("FAIL iread_timeout got no start pulse want read_o"); end
    checks++;
    if ({obs_rd, obs_wr} !== 2'b10) begin errors++; $display("FAIL iread_op got rd/wr %b want 10", {obs_rd, obs_wr}); end
    checks++;
    if (obs_addr !== 32'h0000_1040) begin errors++; $display("FAIL iread_addr got %h want 00001040", obs_addr); end
    checks++;
    if ({ifc.i_resp_o, ifc.d_resp_o} !== 2'b10) begin
      errors++; $display("FAIL iread_resp got i/d %b want 10", {ifc.i_resp_o, ifc.d_resp_o});
    end
    checks++;
    if (ifc.i_line_o !== a5) begin errors++; $display("FAIL iread_line got %h want %h", ifc.i_line_o, a5); end
    ifc.i_read_i = 1'b0;
    m_i_line = a5; m_last_d = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (n_rd - rd0 != 1 || n_iresp - ir0 != 1 || n_dresp - dr0 != 0) begin
      errors++;
      $display("FAIL iread_counts got rd %0d iresp %0d dresp %0d want 1 1 0", n_rd - rd0, n_iresp - ir0, n_dresp - dr0);
    end
  endtask

  task automatic test_d_write();
    logic [255:0] p;
    int wr0, dr0;
    p = rand256();
    wr0 = n_wr; dr0 = n_dresp;
    ifc.d_address_i = 32'h8000_0020; ifc.d_write_i = 1'b1; ifc.d_line_i = p;
    serve(5, rand256());
    checks++;
    if (obs_to !== 1'b0 || {obs_rd, obs_wr} !== 2'b01) begin
      errors++; $display("FAIL dwrite_op got to %b rd/wr %b want 0 01", obs_to, {obs_rd, obs_wr});
    end
    checks++;
    if (obs_addr !== 32'h8000_0020 || obs_wline !== p) begin
      errors++; $display("FAIL dwrite_bus got addr %h line %h want 80000020 %h", obs_addr, obs_wline, p);
    end
    checks++;
    if (obs_unstable != 0) begin errors++; $display("FAIL dwrite_stable got %0d changes want 0", obs_unstable); end
    checks++;
    if ({ifc.i_resp_o, ifc.d_resp_o} !== 2'b01) begin
      errors++; $display("FAIL dwrite_resp got i/d %b want 01", {ifc.i_resp_o, ifc.d_resp_o});
    end
    checks++;
    if (ifc.d_line_o !== m_d_line) begin errors++; $display("FAIL dwrite_dline got %h want %h", ifc.d_line_o, m_d_line); end
    ifc.d_write_i = 1'b0;
    m_last_d = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (n_wr - wr0 != 1 || n_dresp - dr0 != 1) begin
      errors++; $display("FAIL dwrite_counts got wr %0d dresp %0d want 1 1", n_wr - wr0, n_dresp - dr0);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0]  ai, ad;
    logic [255:0] rl;
    bit           exp_d;
    do_reset();
    ai = $urandom; ad = $urandom;
    ifc.i_address_i = ai; ifc.d_address_i = ad;
    ifc.i_read_i = 1'b1; ifc.d_read_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      rl = rand256();
      serve($urandom_range(1, 4), rl);
      checks++;
      if (obs_to !== 1'b0 || obs_addr !== (exp_d ? ad : ai)) begin
        errors++; $display("FAIL rr_addr[%0d] got to %b addr %h want %h", k, obs_to, obs_addr, exp_d ? ad : ai);
      end
      checks++;
      if ({ifc.i_resp_o, ifc.d_resp_o} !== (exp_d ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_owner[%0d] got i/d %b want %b", k, {ifc.i_resp_o, ifc.d_resp_o}, exp_d ? 2'b01 : 2'b10);
      end
      if (exp_d) m_d_line = rl; else m_i_line = rl;
      m_last_d = exp_d;
      checks++;
      if (ifc.i_line_o !== m_i_line || ifc.d_line_o !== m_d_line) begin
        errors++; $display("FAIL rr_lines[%0d] got i %h d %h", k, ifc.i_line_o, ifc.d_line_o);
      end
    end
    ifc.i_read_i = 1'b0; ifc.d_read_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stale();
    logic [255:0] rl;
    int rd0;
    rd0 = n_rd;
    rl = rand256();
    ifc.i_address_i = $urandom; ifc.i_read_i = 1'b1;
    serve(2, rl);
    m_i_line = rl; m_last_d = 1'b0;
    @(negedge clk);
    ifc.i_read_i = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (n_rd - rd0 != 1) begin errors++; $display("FAIL stale_reissue got %0d read pulses want 1", n_rd - rd0); end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] rl;
    logic [31:0]  ad;
    int n, ir0;
    ifc.i_address_i = $urandom | 32'h1; ifc.i_read_i = 1'b1;
    n = 0;
    while (!ifc.read_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (ifc.read_o !== 1'b1) begin errors++; $display("FAIL rst_mid_start got read_o %b want 1", ifc.read_o); end
    repeat (2) @(negedge clk);
    ir0 = n_iresp;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ifc.read_o, ifc.write_o, ifc.i_resp_o, ifc.d_resp_o} !== 4'b0 || ifc.address_o !== 32'h0 || ifc.line_o !== 256'h0) begin
      errors++; $display("FAIL rst_mid_outputs got ctrl %b addr %h want 0", {ifc.read_o, ifc.write_o, ifc.i_resp_o, ifc.d_resp_o}, ifc.address_o);
    end
    clear_inputs();
    m_last_d = 1'b0; m_i_line = '0; m_d_line = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (n_iresp - ir0 != 0) begin errors++; $display("FAIL rst_mid_noresp got %0d i resp want 0", n_iresp - ir0); end
    ad = $urandom; rl = rand256();
    ifc.d_address_i = ad; ifc.d_read_i = 1'b1;
    serve(3, rl);
    checks++;
    if (obs_to !== 1'b0 || {obs_rd, obs_wr} !== 2'b10 || obs_addr !== ad) begin
      errors++; $display("FAIL rst_mid_next got to %b rd/wr %b addr %h want 0 10 %h", obs_to, {obs_rd, obs_wr}, obs_addr, ad);
    end
    checks++;
    if (ifc.d_resp_o !== 1'b1 || ifc.d_line_o !== rl) begin
      errors++; $display("FAIL rst_mid_dline got resp %b line %h want 1 %h", ifc.d_resp_o, ifc.d_line_o, rl);
    end
    m_d_line = rl; m_last_d = 1'b1;
    ifc.d_read_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spurious_resp();
    int ir0, dr0, rd0;
    ir0 = n_iresp; dr0 = n_dresp; rd0 = n_rd;
    ifc.resp_i = 1'b1; ifc.line_i = rand256();
    @(negedge clk);
    ifc.resp_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (n_iresp - ir0 != 0 || n_dresp - dr0 != 0 || n_rd - rd0 != 0) begin
      errors++; $display("FAIL spurious_resp got iresp %0d dresp %0d rd %0d want 0", n_iresp - ir0, n_dresp - dr0, n_rd - rd0);
    end
    checks++;
    if (ifc.i_line_o !== m_i_line || ifc.d_line_o !== m_d_line) begin
      errors++; $display("FAIL spurious_lines got i %h d %h want i %h d %h", ifc.i_line_o, ifc.d_line_o, m_i_line, m_d_line);
    end
  endtask

  task automatic test_random();
    bit           pend_i, pend_d, d_wr, exp_d, exp_wr;
    logic [31:0]  ai, ad;
    logic [255:0] dl, rl;
    pend_i = 1'b0; pend_d = 1'b0; d_wr = 1'b0;
    ai = '0; ad = '0; dl = '0;
    for (int t = 0; t < 40; t++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) begin
        pend_i = 1'b1; ai = $urandom;
        ifc.i_address_i = ai; ifc.i_read_i = 1'b1;
      end
      if (!pend_d && $urandom_range(0, 1) == 1) begin
        pend_d = 1'b1; ad = $urandom; dl = rand256(); d_wr = ($urandom_range(0, 1) == 1);
        ifc.d_address_i = ad; ifc.d_line_i = dl; ifc.d_write_i = d_wr; ifc.d_read_i = !d_wr;
      end
      if (!pend_i && !pend_d) begin
        pend_i = 1'b1; ai = $urandom;
        ifc.i_address_i = ai; ifc.i_read_i = 1'b1;
      end
      exp_d  = pend_d && (!pend_i || !m_last_d);
      exp_wr = exp_d && d_wr;
      rl = rand256();
      serve($urandom_range(1, 6), rl);
      checks++;
      if (obs_to !== 1'b0 || {obs_rd, obs_wr} !== {!exp_wr, exp_wr}) begin
        errors++; $display("FAIL rand_op[%0d] got to %b rd/wr %b want 0 %b", t, obs_to, {obs_rd, obs_wr}, {!exp_wr, exp_wr});
      end
      checks++;
      if (obs_addr !== (exp_d ? ad : ai) || (exp_wr && obs_wline !== dl) || obs_unstable != 0) begin
        errors++; $display("FAIL rand_bus[%0d] got addr %h unstable %0d want %h", t, obs_addr, obs_unstable, exp_d ? ad : ai);
      end
      checks++;
      if ({ifc.i_resp_o, ifc.d_resp_o} !== (exp_d ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rand_owner[%0d] got i/d %b want %b", t, {ifc.i_resp_o, ifc.d_resp_o}, exp_d ? 2'b01 : 2'b10);
      end
      if (!exp_wr) begin
        if (exp_d) m_d_line = rl; else m_i_line = rl;
      end
      m_last_d = exp_d;
      checks++;
      if (ifc.i_line_o !== m_i_line || ifc.d_line_o !== m_d_line) begin
        errors++; $display("FAIL rand_lines[%0d] got i %h d %h want i %h d %h", t, ifc.i_line_o, ifc.d_line_o, m_i_line, m_d_line);
      end
      if (exp_d) begin
        pend_d = 1'b0; ifc.d_read_i = 1'b0; ifc.d_write_i = 1'b0;
      end else begin
        pend_i = 1'b0; ifc.i_read_i = 1'b0;
      end
    end
    clear_inputs();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (n_both != 0) begin errors++; $display("FAIL pulse_overlap got %0d cycles with read_o and write_o want 0", n_both); end
    checks++;
    if (n_consec != 0) begin errors++; $display("FAIL pulse_consecutive got %0d back-to-back pulses want 0", n_consec); end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_round_robin();
    test_stale();
    test_reset_mid_burst();
    test_spurious_resp();
    test_random();
    test_pulse_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
